// File: rtl/axi_pkg.sv
// axi_pkg: AXI burst/response encodings, FSM state types and beat address arithmetic
package axi_pkg;
    typedef enum logic [1:0] {BURST_FIXED = 2'b00, BURST_INCR = 2'b01, BURST_WRAP = 2'b10} burst_t;
    typedef enum logic [1:0] {RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10} resp_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} write_state_t;
    typedef enum logic {R_IDLE, R_BURST} read_state_t;

    // Address of the beat after addr; WRAP with an illegal length and the reserved encoding behave as INCR
    function automatic logic [63:0] next_addr(input logic [63:0] addr, input logic [7:0] len,
                                              input logic [2:0] size, input logic [1:0] burst);
        logic [63:0] step;
        logic [63:0] aligned;
        logic [63:0] mask;
        logic        wrap;
        step    = 64'd1 << size;
        aligned = addr & ~(step - 64'd1);
        mask    = ((64'(len) + 64'd1) << size) - 64'd1;
        wrap    = burst == BURST_WRAP && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
        return burst == BURST_FIXED ? addr
             : wrap ? (aligned & ~mask) | ((aligned + step) & mask)
             : aligned + step;
    endfunction
endpackage

// File: rtl/axi_burst_addr.sv
// axi_burst_addr: next beat address of an AXI burst
module axi_burst_addr
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 20
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [7:0]            len,
    input  logic [2:0]            size,
    input  logic [1:0]            burst,
    output logic [ADDR_WIDTH-1:0] addr_next
);
    assign addr_next = ADDR_WIDTH'(next_addr(64'(addr), len, size, burst));
endmodule

// File: rtl/axi_burst_ram.sv
// axi_burst_ram: AXI4 burst RAM slave with independent read/write channels and optional lane reversal
module axi_burst_ram
    import axi_pkg::*;
#(
    parameter int    DATA_WIDTH = 64,
    parameter int    ADDR_WIDTH = 20,
    parameter int    ID_WIDTH   = 4,
    parameter bit    BYTE_SWAP  = 1,
    parameter string INIT_FILE  = ""
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [ID_WIDTH-1:0]     awid,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [7:0]              awlen,
    input  logic [2:0]              awsize,
    input  logic [1:0]              awburst,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [ID_WIDTH-1:0]     bid,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ID_WIDTH-1:0]     arid,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [7:0]              arlen,
    input  logic [2:0]              arsize,
    input  logic [1:0]              arburst,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [ID_WIDTH-1:0]     rid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic                    rvalid,
    input  logic                    rready
);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int LB    = $clog2(NB);
    localparam int WORDS = 2 ** (ADDR_WIDTH - LB);

    logic [DATA_WIDTH-1:0] mem [WORDS] = '{default: '0};

    write_state_t          w_state, w_next;
    read_state_t           r_state, r_next;
    logic                  live;
    logic [ID_WIDTH-1:0]   aw_id, ar_id;
    logic [ADDR_WIDTH-1:0] aw_addr, ar_addr, aw_addr_next, ar_addr_next;
    logic [7:0]            aw_len, ar_len, w_cnt, r_cnt;
    logic [2:0]            aw_size, ar_size;
    logic [1:0]            aw_burst, ar_burst;
    logic                  aw_err, ar_err;
    logic                  aw_fire, w_fire, ar_fire, r_issue;
    logic [DATA_WIDTH-1:0] wdata_mem, rdata_bus, rd_word;
    logic [NB-1:0]         wstrb_mem;
    logic                  unused_wlast;

    assign aw_fire      = awvalid && awready;
    assign w_fire       = wvalid && wready;
    assign ar_fire      = arvalid && arready;
    assign r_issue      = r_state == R_BURST && (!rvalid || rready);
    assign rd_word      = mem[ar_addr[ADDR_WIDTH-1:LB]];
    assign bid          = aw_id;
    assign bresp        = aw_err ? RESP_SLVERR : RESP_OKAY;
    assign unused_wlast = wlast;

    for (genvar k = 0; k < NB; k++) begin : g_lane
        localparam int M = BYTE_SWAP ? NB - 1 - k : k;
        assign wdata_mem[8*M +: 8]  = wdata[8*k +: 8];
        assign wstrb_mem[M]         = wstrb[k];
        assign rdata_bus[8*k +: 8]  = rd_word[8*M +: 8];
    end

    axi_burst_addr #(.ADDR_WIDTH(ADDR_WIDTH)) u_waddr (
        .addr(aw_addr), .len(aw_len), .size(aw_size), .burst(aw_burst), .addr_next(aw_addr_next)
    );

    axi_burst_addr #(.ADDR_WIDTH(ADDR_WIDTH)) u_raddr (
        .addr(ar_addr), .len(ar_len), .size(ar_size), .burst(ar_burst), .addr_next(ar_addr_next)
    );

    // State registers; live keeps every ready low for the first cycle out of reset
    always_ff @(posedge clock) begin
        if (reset) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
            live    <= 1'b0;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
            live    <= 1'b1;
        end
    end

    // Next state and handshake outputs of both channels; the beat counter, not wlast, ends a write
    always_comb begin
        awready = live && w_state == W_IDLE;
        wready  = live && w_state == W_DATA;
        bvalid  = w_state == W_RESP;
        arready = live && r_state == R_IDLE;
        w_next  = w_state == W_IDLE ? (awvalid && awready ? W_DATA : W_IDLE)
                : w_state == W_DATA ? (wvalid && wready && w_cnt == 8'd0 ? W_RESP : W_DATA)
                : (bready ? W_IDLE : W_RESP);
        r_next  = r_state == R_IDLE ? (arvalid && arready ? R_BURST : R_IDLE)
                : (r_issue && r_cnt == 8'd0 ? R_IDLE : R_BURST);
    end

    // Write command latch and per-beat address/counter advance
    always_ff @(posedge clock) begin
        if (reset) begin
            aw_id    <= '0;
            aw_addr  <= '0;
            aw_len   <= '0;
            aw_size  <= '0;
            aw_burst <= '0;
            aw_err   <= 1'b0;
            w_cnt    <= '0;
        end else if (aw_fire) begin
            aw_id    <= awid;
            aw_addr  <= awaddr;
            aw_len   <= awlen;
            aw_size  <= awsize;
            aw_burst <= awburst;
            aw_err   <= awsize > 3'(LB);
            w_cnt    <= awlen;
        end else if (w_fire) begin
            aw_addr  <= aw_addr_next;
            w_cnt    <= w_cnt - 8'd1;
        end
    end

    // Byte-strobed memory write; oversized bursts and the reset edge leave memory untouched
    always_ff @(posedge clock) begin
        if (w_fire && !aw_err && !reset)
            for (int i = 0; i < NB; i++)
                if (wstrb_mem[i])
                    mem[aw_addr[ADDR_WIDTH-1:LB]][8*i +: 8] <= wdata_mem[8*i +: 8];
    end

    // Read command latch and output register; memory is sampled before any same-edge write lands
    always_ff @(posedge clock) begin
        if (reset) begin
            ar_id    <= '0;
            ar_addr  <= '0;
            ar_len   <= '0;
            ar_size  <= '0;
            ar_burst <= '0;
            ar_err   <= 1'b0;
            r_cnt    <= '0;
            rvalid   <= 1'b0;
            rlast    <= 1'b0;
            rid      <= '0;
            rdata    <= '0;
            rresp    <= '0;
        end else begin
            if (ar_fire) begin
                ar_id    <= arid;
                ar_addr  <= araddr;
                ar_len   <= arlen;
                ar_size  <= arsize;
                ar_burst <= arburst;
                ar_err   <= arsize > 3'(LB);
                r_cnt    <= arlen;
            end
            if (r_issue) begin
                ar_addr <= ar_addr_next;
                r_cnt   <= r_cnt - 8'd1;
                rvalid  <= 1'b1;
                rlast   <= r_cnt == 8'd0;
                rid     <= ar_id;
                rdata   <= ar_err ? '0 : rdata_bus;
                rresp   <= ar_err ? RESP_SLVERR : RESP_OKAY;
            end else if (rready) begin
                rvalid  <= 1'b0;
                rlast   <= 1'b0;
            end
        end
    end
endmodule
